tdp_bram_ctrl: RTL

Parametrised single-clock true dual-port block RAM with a built-in post-reset clear sequencer. Both ports can read and write. Read-during-write is configurable per port, and cross-port address collisions are detected and reported. Used as the generic on-chip buffer for datapath blocks that previously needed a fixed 16x8 RAM.

---
 rtl/tdp_bram_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/tdp_bram_ctrl.sv
// tdp_bram_ctrl: single-clock true dual-port RAM with post-reset clear sequencer.
// Optional TDP_BRAM_OUT_REG_EN adds an output register stage (latency 2).
module tdp_bram_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int RDW_MODE_A = 0,
    parameter int RDW_MODE_B = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_done,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    output logic              valid_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b,
    output logic              valid_b,
    output logic              collision
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic {CLEAR, READY} state_t;
    state_t state, state_nxt;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic acc_a, acc_b, wr_a, wr_b, wb_en, coll_nxt;
    logic wa_en;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_data, rd_a, rd_b;
    logic [DATA_W-1:0] dout_a_q, dout_b_q;
    logic valid_a_q, valid_b_q, coll_q;
    always_comb begin
        state_nxt = state;
        if (state == CLEAR && &clr_addr) state_nxt = READY;
        acc_a = state == READY && en_a;
        acc_b = state == READY && en_b;
        wr_a = acc_a && we_a;
        wr_b = acc_b && we_b;
        coll_nxt = acc_a && acc_b && addr_a == addr_b && (we_a || we_b);
        // port A wins a same-address double write
        wb_en = wr_b && !(wr_a && addr_a == addr_b);
        wa_en = state == CLEAR || wr_a;
        wa_addr = state == CLEAR ? clr_addr : addr_a;
        wa_data = state == CLEAR ? INIT_VAL : din_a;
        rd_a = (wr_a && RDW_MODE_A == 1) ? din_a : mem[addr_a];
        rd_b = (wr_b && RDW_MODE_B == 1) ? din_b : mem[addr_b];
    end
    assign init_done = state == READY;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            clr_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (wa_en) mem[wa_addr] <= wa_data;
            if (wb_en) mem[addr_b] <= din_b;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_a_q <= '0;
            dout_b_q <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            coll_q <= 1'b0;
        end else begin
            valid_a_q <= acc_a;
            valid_b_q <= acc_b;
            coll_q <= coll_nxt;
            if (acc_a) dout_a_q <= rd_a;
            if (acc_b) dout_b_q <= rd_b;
        end
    end
`ifdef TDP_BRAM_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_a <= '0;
            dout_b <= '0;
            valid_a <= 1'b0;
            valid_b <= 1'b0;
            collision <= 1'b0;
        end else begin
            dout_a <= dout_a_q;
            dout_b <= dout_b_q;
            valid_a <= valid_a_q;
            valid_b <= valid_b_q;
            collision <= coll_q;
        end
    end
`else
    assign dout_a = dout_a_q;
    assign dout_b = dout_b_q;
    assign valid_a = valid_a_q;
    assign valid_b = valid_b_q;
    assign collision = coll_q;
`endif
endmodule
